// File: rtl/i2c_bus_monitor.sv
// Multi-channel I2C bus monitor: START/STOP/byte/ACK decode, sticky errors.
// Define I2C_BUS_MONITOR_SVA_EN to compile protocol assertions and covers.
module i2c_bus_monitor #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int WIN_CYCLES  = 64,
  parameter int CNT_W       = 8,
  parameter int NACK_IS_ERR = 1
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic [NUM_CH-1:0]   rd_en,
  input  logic [NUM_CH-1:0]   rd_empty,
  input  logic [NUM_CH-1:0]   scl,
  input  logic [NUM_CH-1:0]   sda,
  input  logic                err_clr,
  output logic [NUM_CH*8-1:0] mon_byte,
  output logic [NUM_CH-1:0]   mon_byte_vld,
  output logic [NUM_CH-1:0]   mon_ack,
  output logic [NUM_CH-1:0]   bus_busy,
  output logic [NUM_CH*4-1:0] err_flags,
  output logic [CNT_W-1:0]    err_cnt,
  output logic                irq
);

  localparam int WIN_W = $clog2(WIN_CYCLES + 1);
  localparam logic [WIN_W-1:0] WIN_LD = WIN_W'(WIN_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_e;

  logic [NUM_CH*4-1:0] det;
  logic [NUM_CH*4-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                irq_q, irq_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic s_scl, s_sda, p_scl_q, p_sda_q;
    logic start, stop, rise, fall;
    state_e st_q, st_d;
    logic [3:0] bit_cnt_q, bit_cnt_d, eff_cnt;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] byte_q, byte_d;
    logic rose_q, rose_d;
    logic pend_q, pend_d;
    logic pack_q, pack_d;
    logic ack_q, ack_d;
    logic vld_q, vld_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic busy, frame, nack, toggle;

    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        scl_sync_q <= '1;
        sda_sync_q <= '1;
        p_scl_q    <= 1'b1;
        p_sda_q    <= 1'b1;
      end else begin
        scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl[c]};
        sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda[c]};
        p_scl_q    <= s_scl;
        p_sda_q    <= s_sda;
      end
    end

    assign s_scl = scl_sync_q[SYNC_STAGES-1];
    assign s_sda = sda_sync_q[SYNC_STAGES-1];
    assign start = p_scl_q & s_scl & p_sda_q & ~s_sda;
    assign stop  = p_scl_q & s_scl & ~p_sda_q & s_sda;
    assign rise  = ~p_scl_q & s_scl;
    assign fall  = p_scl_q & ~s_scl;

    always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
        st_q      <= IDLE;
        bit_cnt_q <= '0;
        shreg_q   <= '0;
        rose_q    <= 1'b0;
        pend_q    <= 1'b0;
        pack_q    <= 1'b0;
        byte_q    <= '0;
        ack_q     <= 1'b0;
        vld_q     <= 1'b0;
        win_q     <= '0;
      end else begin
        st_q      <= st_d;
        bit_cnt_q <= bit_cnt_d;
        shreg_q   <= shreg_d;
        rose_q    <= rose_d;
        pend_q    <= pend_d;
        pack_q    <= pack_d;
        byte_q    <= byte_d;
        ack_q     <= ack_d;
        vld_q     <= vld_d;
        win_q     <= win_d;
      end
    end

    // rose_q marks an SCL rise still high; a START/STOP on it is not data
    always_comb begin
      st_d      = st_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      rose_d    = rose_q;
      pend_d    = 1'b0;
      pack_d    = pack_q;
      if (start || stop || fall) rose_d = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (start) begin
            st_d      = SHIFT;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (stop) begin
            st_d = IDLE;
          end else if (start) begin
            bit_cnt_d = '0;
          end else if (rise) begin
            shreg_d   = {shreg_q[6:0], s_sda};
            bit_cnt_d = bit_cnt_q + 4'd1;
            rose_d    = 1'b1;
            if (bit_cnt_q == 4'd7) st_d = ACK;
          end
        end
        ACK: begin
          if (stop) begin
            st_d = IDLE;
          end else if (start) begin
            st_d      = SHIFT;
            bit_cnt_d = '0;
          end else if (rise) begin
            st_d      = SHIFT;
            bit_cnt_d = '0;
            pend_d    = 1'b1;
            pack_d    = ~s_sda;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_comb begin
      eff_cnt = bit_cnt_q - {3'b000, rose_q};
      busy    = (st_q != IDLE);
      frame   = 1'b0;
      nack    = 1'b0;
      if (st_q == SHIFT && (start || stop))
        frame = (eff_cnt != 4'd0);
      if (st_q == ACK && (start || stop))
        frame = 1'b1;
      if (st_q == ACK && rise && s_sda)
        nack = (NACK_IS_ERR != 0);
      toggle = ((s_scl != p_scl_q) || (s_sda != p_sda_q)) &&
               (st_q == IDLE) && (win_q == '0) && !rd_en[c];
      vld_d  = pend_q;
      byte_d = pend_q ? shreg_q : byte_q;
      ack_d  = pend_q ? pack_q : ack_q;
      win_d  = win_q;
      if (rd_en[c]) win_d = WIN_LD;
      else if (win_q != '0) win_d = win_q - 1'b1;
    end

    assign det[4*c +: 4] = {nack, frame, toggle, rd_en[c] & rd_empty[c]};
    assign mon_byte[8*c +: 8] = byte_q;
    assign mon_byte_vld[c]    = vld_q;
    assign mon_ack[c]         = ack_q;
    assign bus_busy[c]        = busy;

`ifdef I2C_BUS_MONITOR_SVA_EN
    a_no_empty_rd: assert property (@(posedge rd_clk) disable iff (rd_rst)
      rd_empty[c] |-> !rd_en[c])
      else $error("ch%0d: read of empty FIFO", c);
    a_no_idle_toggle: assert property (@(posedge rd_clk) disable iff (rd_rst)
      !toggle)
      else $error("ch%0d: bus toggle outside window", c);
    c_start: cover property (@(posedge rd_clk) disable iff (rd_rst)
      start && st_q == IDLE);
    c_rstart: cover property (@(posedge rd_clk) disable iff (rd_rst)
      start && st_q != IDLE);
    c_stop: cover property (@(posedge rd_clk) disable iff (rd_rst)
      stop && st_q != IDLE);
    c_nack: cover property (@(posedge rd_clk) disable iff (rd_rst)
      st_q == ACK && rise && s_sda);
`else
`endif
  end

  always_comb begin
    flags_d = err_clr ? det : (flags_q | det);
    cnt_d   = cnt_q;
    if (err_clr) cnt_d = CNT_W'(|det);
    else if (|det && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    irq_d = |flags_d;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      flags_q <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign err_flags = flags_q;
  assign err_cnt   = cnt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: default build plus CNT_W=2/NACK_IS_ERR=0.
module tb_i2c_bus_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] rd_en, rd_empty, scl, sda;
  logic       err_clr;

  logic [15:0] mb1, mb2;
  logic [1:0]  vld1, vld2, ack1, ack2, busy1, busy2;
  logic [7:0]  fl1, fl2;
  logic [7:0]  cnt1;
  logic [1:0]  cnt2;
  logic        irq1, irq2;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;

  i2c_bus_monitor u_dut (
    .rd_clk(clk), .rd_rst(rst), .rd_en(rd_en), .rd_empty(rd_empty),
    .scl(scl), .sda(sda), .err_clr(err_clr),
    .mon_byte(mb1), .mon_byte_vld(vld1), .mon_ack(ack1),
    .bus_busy(busy1), .err_flags(fl1), .err_cnt(cnt1), .irq(irq1)
  );

  i2c_bus_monitor #(.CNT_W(2), .NACK_IS_ERR(0)) u_dut2 (
    .rd_clk(clk), .rd_rst(rst), .rd_en(rd_en), .rd_empty(rd_empty),
    .scl(scl), .sda(sda), .err_clr(err_clr),
    .mon_byte(mb2), .mon_byte_vld(vld2), .mon_ack(ack2),
    .bus_busy(busy2), .err_flags(fl2), .err_cnt(cnt2), .irq(irq2)
  );

  always @(negedge clk) if (vld1[0]) vcnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_pulse(input int ch);
    rd_en[ch] = 1'b1;
    cyc(1);
    rd_en[ch] = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic i2c_start(input int ch);
    cyc(3);
    sda[ch] = 1'b0;
    cyc(3);
    scl[ch] = 1'b0;
    cyc(3);
  endtask

  task automatic i2c_bit(input int ch, input logic b);
    sda[ch] = b;
    cyc(3);
    scl[ch] = 1'b1;
    cyc(3);
    scl[ch] = 1'b0;
    cyc(3);
  endtask

  task automatic i2c_byte(input int ch, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) i2c_bit(ch, b[i]);
  endtask

  task automatic i2c_stop(input int ch);
    sda[ch] = 1'b0;
    cyc(3);
    scl[ch] = 1'b1;
    cyc(3);
    sda[ch] = 1'b1;
    cyc(6);
  endtask

  task automatic i2c_rstart(input int ch);
    sda[ch] = 1'b1;
    cyc(3);
    scl[ch] = 1'b1;
    cyc(3);
    sda[ch] = 1'b0;
    cyc(3);
    scl[ch] = 1'b0;
    cyc(3);
  endtask

  initial begin
    rst = 1'b1;
    rd_en = '0;
    rd_empty = '0;
    scl = '1;
    sda = '1;
    err_clr = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(2);
    check("rst_flags", fl1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_busy", busy1, 0);
    check("rst_byte", mb1, 0);
    check("rst_irq", irq1, 0);
    check("rst_vld", vld1, 0);

    // write 0xA5 with ACK, STOP while SCL still high after 9th clock
    rd_pulse(0);
    i2c_start(0);
    check("t1_busy_on", busy1[0], 1);
    i2c_byte(0, 8'hA5);
    sda[0] = 1'b0;
    cyc(3);
    scl[0] = 1'b1;
    cyc(3);
    check("t1_vld_early", vld1[0], 0);
    cyc(1);
    check("t1_vld", vld1[0], 1);
    check("t1_byte", mb1[7:0], 8'hA5);
    check("t1_ack", ack1[0], 1);
    cyc(1);
    check("t1_vld_end", vld1[0], 0);
    sda[0] = 1'b1;
    cyc(6);
    check("t1_busy_off", busy1[0], 0);
    check("t1_flags", fl1, 0);
    check("t1_vcnt", vcnt, 1);

    // empty read on ch1 for 3 cycles
    rd_en[1] = 1'b1;
    rd_empty[1] = 1'b1;
    cyc(3);
    rd_en[1] = 1'b0;
    rd_empty[1] = 1'b0;
    cyc(2);
    check("t2_flags", fl1, 8'h10);
    check("t2_cnt", cnt1, 3);
    check("t2_irq", irq1, 1);
    check("t2_cnt2", cnt2, 3);
    clr();
    check("t2_clr_flags", fl1, 0);
    check("t2_clr_cnt", cnt1, 0);
    check("t2_clr_irq", irq1, 0);

    // idle toggle outside / inside the window
    rd_pulse(0);
    cyc(100);
    scl[0] = 1'b0;
    cyc(3);
    scl[0] = 1'b1;
    cyc(4);
    check("t3_late_flags", fl1, 8'h02);
    check("t3_late_cnt", cnt1, 2);
    clr();
    rd_pulse(0);
    cyc(10);
    scl[0] = 1'b0;
    cyc(3);
    scl[0] = 1'b1;
    cyc(4);
    check("t3_win_flags", fl1, 0);
    check("t3_win_cnt", cnt1, 0);

    // short frame: 4 bits then STOP
    rd_pulse(0);
    i2c_start(0);
    i2c_bit(0, 1'b1);
    i2c_bit(0, 1'b0);
    i2c_bit(0, 1'b1);
    i2c_bit(0, 1'b1);
    i2c_stop(0);
    check("t4_frame", fl1, 8'h04);
    check("t4_cnt", cnt1, 1);
    check("t4_vcnt", vcnt, 1);
    check("t4_busy", busy1[0], 0);
    clr();

    // full byte + ACK, repeated START, STOP: legal
    rd_pulse(0);
    i2c_start(0);
    i2c_byte(0, 8'h55);
    i2c_bit(0, 1'b0);
    i2c_rstart(0);
    check("t4_rs_busy", busy1[0], 1);
    i2c_stop(0);
    check("t4_rs_flags", fl1, 0);
    check("t4_rs_vcnt", vcnt, 2);
    check("t4_rs_byte", mb1[7:0], 8'h55);
    check("t4_rs_ack", ack1[0], 1);
    check("t4_rs_busy_off", busy1[0], 0);

    // 0x3C NACKed
    rd_pulse(0);
    i2c_start(0);
    i2c_byte(0, 8'h3C);
    i2c_bit(0, 1'b1);
    i2c_stop(0);
    check("t5_byte", mb1[7:0], 8'h3C);
    check("t5_ack", ack1[0], 0);
    check("t5_flags", fl1, 8'h08);
    check("t5_cnt", cnt1, 1);
    check("t5_vcnt", vcnt, 3);
    check("t5_ack2", ack2[0], 0);
    check("t5_flags2", fl2, 0);
    check("t5_cnt2", cnt2, 0);
    clr();

    // saturation with CNT_W=2, then clear with simultaneous event
    rd_en = 2'b10;
    rd_empty = 2'b10;
    cyc(4);
    rd_en = 2'b01;
    rd_empty = 2'b01;
    cyc(1);
    rd_en = 2'b00;
    rd_empty = 2'b00;
    cyc(2);
    check("t6_sat_cnt2", cnt2, 3);
    check("t6_cnt", cnt1, 5);
    check("t6_flags2", fl2, 8'h11);
    rd_en = 2'b10;
    rd_empty = 2'b10;
    err_clr = 1'b1;
    cyc(1);
    rd_en = 2'b00;
    rd_empty = 2'b00;
    err_clr = 1'b0;
    cyc(1);
    check("t6_clr_cnt2", cnt2, 1);
    check("t6_clr_flags2", fl2, 8'h10);
    check("t6_clr_cnt", cnt1, 1);
    check("t6_clr_irq2", irq2, 1);

    // reset mid-byte
    rd_pulse(0);
    i2c_start(0);
    i2c_bit(0, 1'b1);
    i2c_bit(0, 1'b1);
    i2c_bit(0, 1'b0);
    i2c_bit(0, 1'b1);
    rst = 1'b1;
    scl = '1;
    sda = '1;
    cyc(4);
    check("t7_rst_busy", busy1, 0);
    check("t7_rst_flags", fl1, 0);
    check("t7_rst_cnt", cnt1, 0);
    check("t7_rst_byte", mb1, 0);
    check("t7_rst_ack", ack1, 0);
    rst = 1'b0;
    cyc(10);
    check("t7_vcnt", vcnt, 3);
    check("t7_busy", busy1, 0);
    check("t7_flags", fl1, 0);
    check("t7_irq", irq1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
